// File: rtl/bp_pkg.sv
// bp_pkg: shared 2-bit counter encodings, reset value and saturating update for the branch predictor
package bp_pkg;
  typedef logic [1:0] ctr_t;
  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT = 2'b10;
  localparam ctr_t CTR_ST = 2'b11;
  localparam ctr_t CTR_RESET = CTR_WNT;
  localparam int DEF_INDEX_BITS = 6;
  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    return taken ? ((ctr == CTR_ST) ? CTR_ST : ctr + 2'd1) : ((ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1);
  endfunction
endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch-side prediction request and EX-side training/mispredict signals
interface branch_predictor_if #(parameter int XLEN = 32);
  logic pred_valid;
  logic [XLEN-1:0] pred_pc;
  logic pred_taken;
  logic upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic upd_taken;
  logic upd_pred;
  logic mispredict;
  modport master (
    output pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, upd_pred,
    input pred_taken, mispredict
  );
  modport slave (
    input pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, upd_pred,
    output pred_taken, mispredict
  );
endinterface

// File: rtl/bp_counter_table.sv
// bp_counter_table: bimodal array of 2-bit saturating counters with one read port forwarding a same-index write
module bp_counter_table import bp_pkg::*; #(
  parameter int INDEX_BITS = DEF_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output ctr_t                  rd_ctr,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  wr_taken
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  ctr_t ctr_q [ENTRIES];
  ctr_t ctr_d [ENTRIES];
  ctr_t wr_ctr;
  assign wr_ctr = ctr_next(ctr_q[wr_idx], wr_taken);
  // apply the training step to the addressed entry only
  always_comb begin
    ctr_d = ctr_q;
    if (wr_en) ctr_d[wr_idx] = wr_ctr;
  end
  // a read hitting the entry being trained sees the post-update value
  always_comb rd_ctr = (wr_en && wr_idx == rd_idx) ? wr_ctr : ctr_q[rd_idx];
  // counter storage, every entry returns to weakly not-taken on reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) ctr_q <= '{default: CTR_RESET};
    else ctr_q <= ctr_d;
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: bimodal direction predictor; define BP_PERF_CNT_EN to build the saturating perf counters
module branch_predictor import bp_pkg::*; #(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  branch_predictor_if.slave   bp,
  output logic [31:0]         perf_branch_cnt,
  output logic [31:0]         perf_mispred_cnt
);
  logic [INDEX_BITS-1:0] pred_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  ctr_t pred_ctr;
  logic mispredict_d;
  logic mispredict_q;
  logic unused_pc_bits;
  assign pred_idx = bp.pred_pc[INDEX_BITS+1:2];
  assign upd_idx = bp.upd_pc[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{bp.pred_pc[XLEN-1:INDEX_BITS+2], bp.pred_pc[1:0],
                            bp.upd_pc[XLEN-1:INDEX_BITS+2], bp.upd_pc[1:0]};
  bp_counter_table #(.INDEX_BITS(INDEX_BITS)) u_table (
    .clk(clk),
    .rst(rst),
    .rd_idx(pred_idx),
    .rd_ctr(pred_ctr),
    .wr_en(bp.upd_valid),
    .wr_idx(upd_idx),
    .wr_taken(bp.upd_taken)
  );
  assign bp.pred_taken = rst & bp.pred_valid & pred_ctr[1];
  // a resolved branch whose outcome disagrees with its issued prediction
  always_comb mispredict_d = bp.upd_valid & (bp.upd_taken ^ bp.upd_pred);
  // one-cycle mispredict pulse towards the flush logic
  always_ff @(posedge clk or negedge rst)
    if (!rst) mispredict_q <= 1'b0;
    else mispredict_q <= mispredict_d;
  assign bp.mispredict = mispredict_q;
`ifdef BP_PERF_CNT_EN
  logic [31:0] branch_cnt_d;
  logic [31:0] branch_cnt_q;
  logic [31:0] mispred_cnt_d;
  logic [31:0] mispred_cnt_q;
  // event counters stick at all-ones instead of wrapping
  always_comb begin
    branch_cnt_d = (bp.upd_valid && branch_cnt_q != '1) ? branch_cnt_q + 32'd1 : branch_cnt_q;
    mispred_cnt_d = (mispredict_d && mispred_cnt_q != '1) ? mispred_cnt_q + 32'd1 : mispred_cnt_q;
  end
  // perf counter registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      branch_cnt_q <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  assign perf_branch_cnt = branch_cnt_q;
  assign perf_mispred_cnt = mispred_cnt_q;
`else
  assign perf_branch_cnt = '0;
  assign perf_mispred_cnt = '0;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed checks of prediction, training, saturation, aliasing, forwarding and async reset
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] perf_branch_cnt;
  logic [31:0] perf_mispred_cnt;
  int checks = 0;
  int errors = 0;
  int exp_br = 0;
  int exp_mp = 0;
`ifdef BP_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif
  always #5 clk = ~clk;
  branch_predictor_if #(.XLEN(32)) bp_if ();
  branch_predictor #(.INDEX_BITS(6), .XLEN(32)) dut (
    .clk(clk),
    .rst(rst),
    .bp(bp_if),
    .perf_branch_cnt(perf_branch_cnt),
    .perf_mispred_cnt(perf_mispred_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic predict(input logic [31:0] pc, input logic exp, input string tag);
    bp_if.pred_valid = 1'b1;
    bp_if.pred_pc = pc;
    #1;
    chk(tag, {31'd0, bp_if.pred_taken}, {31'd0, exp});
  endtask
  task automatic perf_chk(input string tag);
    chk({tag, "_branch_cnt"}, perf_branch_cnt, PERF_EN ? 32'(exp_br) : 32'd0);
    chk({tag, "_mispred_cnt"}, perf_mispred_cnt, PERF_EN ? 32'(exp_mp) : 32'd0);
  endtask
  task automatic update(input logic [31:0] pc, input logic t, input logic p);
    bp_if.pred_valid = 1'b0;
    bp_if.upd_valid = 1'b1;
    bp_if.upd_pc = pc;
    bp_if.upd_taken = t;
    bp_if.upd_pred = p;
    tick;
    bp_if.upd_valid = 1'b0;
    exp_br++;
    if (t != p) exp_mp++;
    chk("mispredict", {31'd0, bp_if.mispredict}, {31'd0, t != p});
  endtask
  initial begin
    rst = 1'b0;
    bp_if.pred_valid = 1'b1;
    bp_if.pred_pc = 32'h100;
    bp_if.upd_valid = 1'b0;
    bp_if.upd_pc = '0;
    bp_if.upd_taken = 1'b0;
    bp_if.upd_pred = 1'b0;
    #2;
    chk("pred_in_reset", {31'd0, bp_if.pred_taken}, 32'd0);
    tick;
    tick;
    rst = 1'b1;
    predict(32'h100, 1'b0, "pred_after_reset");
    chk("mispredict_after_reset", {31'd0, bp_if.mispredict}, 32'd0);
    perf_chk("reset");
    update(32'h100, 1'b1, 1'b0);
    predict(32'h100, 1'b1, "pred_trained_10");
    perf_chk("first_update");
    tick;
    chk("mispredict_one_cycle", {31'd0, bp_if.mispredict}, 32'd0);
    for (int i = 0; i < 4; i++) update(32'h100, 1'b1, 1'b1);
    update(32'h100, 1'b0, 1'b1);
    predict(32'h100, 1'b1, "sat_hi_then_10");
    update(32'h100, 1'b0, 1'b0);
    predict(32'h100, 1'b0, "sat_down_01");
    update(32'h100, 1'b0, 1'b0);
    update(32'h100, 1'b0, 1'b0);
    update(32'h100, 1'b1, 1'b0);
    predict(32'h100, 1'b0, "sat_lo_then_01");
    update(32'h100, 1'b1, 1'b0);
    predict(32'h100, 1'b1, "sat_lo_then_10");
    perf_chk("saturation");
    update(32'h100, 1'b1, 1'b1);
    update(32'h100, 1'b1, 1'b1);
    predict(32'h200, 1'b1, "alias_200");
    predict(32'h104, 1'b0, "alias_104");
    predict(32'h1103, 1'b1, "alias_upper_low_bits");
    bp_if.pred_valid = 1'b0;
    bp_if.pred_pc = 32'h100;
    #1;
    chk("pred_valid_low", {31'd0, bp_if.pred_taken}, 32'd0);
    tick;
    predict(32'h40, 1'b0, "fwd_before");
    bp_if.upd_valid = 1'b1;
    bp_if.upd_pc = 32'h40;
    bp_if.upd_taken = 1'b1;
    bp_if.upd_pred = 1'b0;
    #1;
    chk("fwd_increment", {31'd0, bp_if.pred_taken}, 32'd1);
    tick;
    bp_if.upd_valid = 1'b0;
    exp_br++;
    exp_mp++;
    chk("fwd_mispredict", {31'd0, bp_if.mispredict}, 32'd1);
    #1;
    chk("fwd_stored", {31'd0, bp_if.pred_taken}, 32'd1);
    bp_if.upd_valid = 1'b1;
    bp_if.upd_taken = 1'b0;
    bp_if.upd_pred = 1'b1;
    #1;
    chk("fwd_decrement", {31'd0, bp_if.pred_taken}, 32'd0);
    tick;
    bp_if.upd_valid = 1'b0;
    exp_br++;
    exp_mp++;
    perf_chk("forwarding");
    for (int i = 0; i < 3; i++) update(32'h40, 1'b1, 1'b1);
    update(32'h80, 1'b1, 1'b1);
    update(32'h80, 1'b1, 1'b1);
    update(32'h80, 1'b1, 1'b0);
    perf_chk("pre_reset");
    bp_if.pred_valid = 1'b1;
    bp_if.pred_pc = 32'h40;
    bp_if.upd_valid = 1'b1;
    bp_if.upd_pc = 32'h80;
    bp_if.upd_taken = 1'b0;
    bp_if.upd_pred = 1'b1;
    #1;
    chk("pre_reset_pred", {31'd0, bp_if.pred_taken}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    exp_br = 0;
    exp_mp = 0;
    chk("async_rst_pred", {31'd0, bp_if.pred_taken}, 32'd0);
    chk("async_rst_mispredict", {31'd0, bp_if.mispredict}, 32'd0);
    perf_chk("async_rst");
    tick;
    #2;
    bp_if.upd_valid = 1'b0;
    rst = 1'b1;
    predict(32'h40, 1'b0, "post_rst_40");
    predict(32'h80, 1'b0, "post_rst_80");
    predict(32'h100, 1'b0, "post_rst_100");
    chk("post_rst_mispredict", {31'd0, bp_if.mispredict}, 32'd0);
    perf_chk("post_rst");
    update(32'h80, 1'b1, 1'b1);
    predict(32'h80, 1'b1, "post_rst_80_was_wnt");
    update(32'h40, 1'b1, 1'b1);
    predict(32'h40, 1'b1, "post_rst_40_was_wnt");
    perf_chk("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch direction predictor. It is the producer end of the branch-taken signal that the EX-stage branch comparator resolves.
- Holds a bimodal table of 2-bit saturating counters indexed by PC.
- Predicts taken/not-taken for the fetch PC.
- Trains on the resolved outcome (comparator BSrc) returned from EX.
- Reports mispredictions to the hazard/flush logic.

Parameters:
- INDEX_BITS, 6, log2 of table entries (64 entries); index = pc[INDEX_BITS+1:2].
- XLEN, 32, PC width.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pred_valid  in  1  fetch stage requests a prediction this cycle.
- pred_pc  in  XLEN  fetch PC.
- pred_taken  out  1  predicted direction, combinational from pred_pc.
- upd_valid  in  1  EX resolves a conditional branch this cycle.
- upd_pc  in  XLEN  PC of the resolved branch.
- upd_taken  in  1  resolved direction (comparator BSrc).
- upd_pred  in  1  prediction originally issued for this branch, carried down the pipeline.
- mispredict  out  1  registered misprediction pulse to flush logic.
- perf_branch_cnt  out  32  resolved-branch count (see Optional Feature).
- perf_mispred_cnt  out  32  misprediction count (see Optional Feature).

Behaviour:
- Reset (rst=0, async):
  - every table entry = 2'b01 (weakly not-taken);
  - mispredict = 0; perf counters = 0;
  - pred_taken = 0 while rst=0;
  - all inputs ignored.
  - Deassertion mid-operation discards any in-flight update.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predicted direction = bit[1].
- Prediction:
  - pred_taken = pred_valid & ctr[idx(pred_pc)][1]; zero-cycle latency.
  - pred_taken = 0 when pred_valid = 0.
- Update:
  - At the clk edge with upd_valid=1, ctr[idx(upd_pc)] is incremented if upd_taken, else decremented.
  - Saturates: 11 + taken stays 11; 00 + not-taken stays 00.
  - The new value is visible to prediction in the following cycle.
- Same-cycle forwarding:
  - Applies when upd_valid=1, pred_valid=1 and idx(upd_pc)==idx(pred_pc) in the same cycle.
  - pred_taken then reflects the post-update counter value, not the stored one.
- Aliasing: PCs with equal index bits share one entry. There is no tag check; this is by design.
- mispredict:
  - Registered; asserted exactly one cycle after an edge where upd_valid=1 and upd_taken != upd_pred.
  - High for one cycle per mispredicted branch.
  - Back-to-back updates produce back-to-back pulses.
- No stall input: each upd_valid cycle is exactly one training event.
- Upper PC bits and pc[1:0] are ignored.

Optional Feature:
- Macro: BP_PERF_CNT_EN.
- Defined:
  - perf_branch_cnt increments on each upd_valid edge.
  - perf_mispred_cnt increments on each edge where mispredict is set.
  - Both are 32-bit and saturate at 32'hFFFFFFFF (no wrap).
  - Both are cleared by reset.
- Undefined: both ports are tied to 0 and no counter flops are synthesized. Port list is unchanged.

Decomposition:
- Shared package bp_pkg holds:
  - counter-state constants CTR_SNT/CTR_WNT/CTR_WT/CTR_ST;
  - the CTR_RESET value (CTR_WNT);
  - default INDEX_BITS;
  - a pure function for the saturating next-counter value, taking (ctr, taken).
- One sub-module, bp_counter_table: the counter array with async reset, one combinational read port, one write port, and the same-index forwarding mux.
- The top level holds index extraction, the mispredict register and the perf counters.

Test Plan:
- Reset, then pred_valid=1 with pred_pc=0x100 → pred_taken=0; mispredict=0; perf counters=0.
- upd_valid, upd_pc=0x100, upd_taken=1, upd_pred=0 for one cycle:
  - next cycle: mispredict=1 for exactly one cycle;
  - prediction for 0x100 → 1 (entry 01→10);
  - with BP_PERF_CNT_EN: branch_cnt=1, mispred_cnt=1.
- Saturation:
  - four taken updates on 0x100 → entry 11;
  - one not-taken → 10, pred_taken still 1;
  - three more not-taken → 00, then a further not-taken stays 00.
- Aliasing (INDEX_BITS=6): train 0x100 taken twice → predicting 0x200 returns 1 (shared index 0). Predicting 0x104 stays 0.
- Forwarding: entry for 0x40 at 01; same cycle upd_pc=0x40, upd_taken=1 and pred_pc=0x40 → pred_taken=1 in that cycle.
- Async reset mid-operation:
  - after training several entries to 11, drop rst between edges;
  - pred_taken=0 and mispredict=0 immediately;
  - after release, all entries read weakly-NT and perf counters=0.
